// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and constants for the Morse decoder
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      SEND  = 2'd2
   } state_t;

   localparam logic [7:0] SPACE_CHAR = 8'h20;
   localparam logic [7:0] ERR_CHAR   = 8'h3F;

   localparam logic ELEM_DOT  = 1'b0;
   localparam logic ELEM_DASH = 1'b1;

endpackage

// File: rtl/morse_if.sv
// rtl/morse_if.sv - character stream from the decoder to the transmitter/display
interface morse_if;

   logic [7:0] char_out;
   logic       char_valid;
   logic       char_ready;

   modport master (output char_out, output char_valid, input char_ready);
   modport slave  (input char_out, input char_valid, output char_ready);

endinterface

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - Morse pattern to ASCII table, first element at the MSB of the used bits
module morse_lut
   import morse_pkg::*;
(
   input  logic [2:0] elem_cnt,
   input  logic [4:0] elem_bits,
   output logic [7:0] ascii,
   output logic       valid
);

   // key is {element count, right-aligned pattern}; dot=0, dash=1
   always_comb begin
      ascii = ERR_CHAR;
      valid = 1'b1;
      case ({elem_cnt, elem_bits})
         8'b001_00000: ascii = "E";
         8'b001_00001: ascii = "T";
         8'b010_00000: ascii = "I";
         8'b010_00001: ascii = "A";
         8'b010_00010: ascii = "N";
         8'b010_00011: ascii = "M";
         8'b011_00000: ascii = "S";
         8'b011_00001: ascii = "U";
         8'b011_00010: ascii = "R";
         8'b011_00011: ascii = "W";
         8'b011_00100: ascii = "D";
         8'b011_00101: ascii = "K";
         8'b011_00110: ascii = "G";
         8'b011_00111: ascii = "O";
         8'b100_00000: ascii = "H";
         8'b100_00001: ascii = "V";
         8'b100_00010: ascii = "F";
         8'b100_00100: ascii = "L";
         8'b100_00110: ascii = "P";
         8'b100_00111: ascii = "J";
         8'b100_01000: ascii = "B";
         8'b100_01001: ascii = "X";
         8'b100_01010: ascii = "C";
         8'b100_01011: ascii = "Y";
         8'b100_01100: ascii = "Z";
         8'b100_01101: ascii = "Q";
         8'b101_00000: ascii = "5";
         8'b101_00001: ascii = "4";
         8'b101_00011: ascii = "3";
         8'b101_00111: ascii = "2";
         8'b101_01111: ascii = "1";
         8'b101_10000: ascii = "6";
         8'b101_11000: ascii = "7";
         8'b101_11100: ascii = "8";
         8'b101_11110: ascii = "9";
         8'b101_11111: ascii = "0";
         default:      valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - times taps into dots/dashes, buffers letters, streams the message on send
module morse_decoder
   import morse_pkg::*;
#(
   parameter int DASH_CYCLES = 30000000,
   parameter int MAX_ELEMS   = 5,
   parameter int MSG_DEPTH   = 32
) (
   input  logic       cclk,
   input  logic       rstb,
   input  logic       tap,
   input  logic       space,
   input  logic       send,
   morse_if.master    tx,
   output logic [5:0] msg_len,
   output logic       busy,
   output logic       err
);

   localparam int PTR_W = $clog2(MSG_DEPTH);

   state_t           state, state_nxt;
   logic             prev_tap, prev_space, prev_send;
   logic             tap_rise, tap_fall, space_rise, send_rise;
   logic [31:0]      dur;
   logic [4:0]       elem_bits;
   logic [2:0]       elem_cnt;
   logic             ovf;
   logic [7:0]       msg_mem [MSG_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             start_press, classify, commit, enter_send, accept, last_accept;
   logic [7:0]       lut_ascii, commit_char;
   logic             lut_valid, commit_bad, dash, buf_full;

   assign tap_rise   = tap & ~prev_tap;
   assign tap_fall   = ~tap & prev_tap;
   assign space_rise = space & ~prev_space;
   assign send_rise  = send & ~prev_send;
   assign buf_full   = (msg_len == 6'(MSG_DEPTH));
   assign dash       = (dur >= 32'(DASH_CYCLES)) ? ELEM_DASH : ELEM_DOT;

   morse_lut u_lut (
      .elem_cnt  (elem_cnt),
      .elem_bits (elem_bits),
      .ascii     (lut_ascii),
      .valid     (lut_valid)
   );

   // character produced by a commit: word gap, decoded letter, or '?' for bad/overflowed patterns
   always_comb begin
      commit_char = lut_ascii;
      commit_bad  = 1'b0;
      if (elem_cnt == 3'd0) begin
         commit_char = SPACE_CHAR;
      end else if (ovf || !lut_valid) begin
         commit_char = ERR_CHAR;
         commit_bad  = 1'b1;
      end
   end

   // state register
   always_ff @(posedge cclk) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and control strobes; send beats space beats tap within a cycle
   always_comb begin
      state_nxt      = state;
      start_press    = 1'b0;
      classify       = 1'b0;
      commit         = 1'b0;
      enter_send     = 1'b0;
      accept         = 1'b0;
      last_accept    = 1'b0;
      busy           = 1'b0;
      tx.char_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (send_rise) begin
               if (msg_len != 6'd0) begin
                  state_nxt  = SEND;
                  enter_send = 1'b1;
               end
            end else if (space_rise) begin
               commit = 1'b1;
            end else if (tap_rise) begin
               state_nxt   = PRESS;
               start_press = 1'b1;
            end
         end
         PRESS: begin
            if (send_rise && msg_len != 6'd0) begin
               state_nxt  = SEND;
               enter_send = 1'b1;
            end else if (tap_fall) begin
               state_nxt = IDLE;
               classify  = 1'b1;
            end
         end
         SEND: begin
            busy          = 1'b1;
            tx.char_valid = 1'b1;
            if (tx.char_ready) begin
               accept = 1'b1;
               if (msg_len == 6'd1) begin
                  last_accept = 1'b1;
                  state_nxt   = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign tx.char_out = (state == SEND) ? msg_mem[rd_ptr] : 8'h00;

   // edge history, press timing, letter pattern, buffer bookkeeping and error pulse
   always_ff @(posedge cclk) begin
      if (!rstb) begin
         prev_tap   <= 1'b0;
         prev_space <= 1'b0;
         prev_send  <= 1'b0;
         dur        <= 32'd0;
         elem_bits  <= 5'd0;
         elem_cnt   <= 3'd0;
         ovf        <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         msg_len    <= 6'd0;
         err        <= 1'b0;
      end else begin
         prev_tap   <= tap;
         prev_space <= space;
         prev_send  <= send;
         err        <= 1'b0;
         if (start_press) begin
            dur <= 32'd1;
         end else if (state == PRESS && tap && dur < 32'(DASH_CYCLES)) begin
            dur <= dur + 32'd1;
         end
         if (classify) begin
            if (elem_cnt < 3'(MAX_ELEMS)) begin
               elem_bits <= {elem_bits[3:0], dash};
               elem_cnt  <= elem_cnt + 3'd1;
            end else begin
               ovf <= 1'b1;
            end
         end
         if (commit || enter_send) begin
            elem_bits <= 5'd0;
            elem_cnt  <= 3'd0;
            ovf       <= 1'b0;
         end
         if (commit) begin
            if (buf_full) begin
               err <= 1'b1;
            end else begin
               wr_ptr  <= wr_ptr + 1'b1;
               msg_len <= msg_len + 6'd1;
               err     <= commit_bad;
            end
         end
         if (last_accept) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            msg_len <= 6'd0;
         end else if (accept) begin
            rd_ptr  <= rd_ptr + 1'b1;
            msg_len <= msg_len - 6'd1;
         end
      end
   end

   // message storage; contents are only meaningful below msg_len so no reset
   always_ff @(posedge cclk) begin
      if (commit && !buf_full) msg_mem[wr_ptr] <= commit_char;
   end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - randomized bench for morse_decoder against a string-level Morse model
module tb_morse_decoder;

   localparam int DASH  = 8;
   localparam int DEPTH = 4;

   logic       cclk = 1'b0;
   logic       rstb = 1'b0;
   logic       tap = 1'b0, space = 1'b0, send = 1'b0;
   logic [5:0] msg_len;
   logic       busy, err;

   morse_if tx ();

   morse_decoder #(.DASH_CYCLES(DASH), .MAX_ELEMS(5), .MSG_DEPTH(DEPTH)) dut (
      .cclk    (cclk),
      .rstb    (rstb),
      .tap     (tap),
      .space   (space),
      .send    (send),
      .tx      (tx),
      .msg_len (msg_len),
      .busy    (busy),
      .err     (err)
   );

   always #5 cclk = ~cclk;

   int         n_cmp = 0;
   int         n_bad = 0;
   string      codes [36];
   string      charset;
   string      pat;
   logic [7:0] q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // tap held for n cycles; the model classifies by duration alone
   task automatic press(input int n);
      tap = 1'b1;
      repeat (n) @(posedge cclk);
      #1 tap = 1'b0;
      pat = {pat, (n >= DASH) ? "-" : "."};
      repeat (2) @(posedge cclk);
      #1;
   endtask

   task automatic type_code(input string code);
      for (int i = 0; i < code.len(); i++) begin
         if (code[i] == "-") press($urandom_range(DASH, DASH + 5));
         else                press($urandom_range(1, DASH - 1));
      end
   endtask

   task automatic commit();
      logic [7:0] ch;
      logic       bad;
      ch  = 8'h20;
      bad = 1'b0;
      if (pat.len() != 0) begin
         ch  = 8'h3F;
         bad = 1'b1;
         for (int i = 0; i < 36; i++)
            if (codes[i] == pat) begin
               ch  = charset[i];
               bad = 1'b0;
            end
      end
      if (q.size() == DEPTH) bad = 1'b1;
      else                   q.push_back(ch);
      pat = "";
      space = 1'b1;
      @(posedge cclk);
      #1 space = 1'b0;
      @(negedge cclk);
      chk("commit_err", err, bad);
      chk("commit_len", msg_len, q.size());
      @(negedge cclk);
      chk("err_width", err, 0);
      @(posedge cclk);
      #1;
   endtask

   // mode 0: random ready; mode 1: ready pattern 1,0,1,1
   task automatic send_msg(input int mode, input bit tap_during);
      logic rdy;
      int   cyc;
      if (q.size() != 0) pat = "";
      send = 1'b1;
      @(posedge cclk);
      #1 send = 1'b0;
      if (q.size() == 0) begin
         @(negedge cclk);
         chk("send_empty_busy", busy, 0);
         chk("send_empty_valid", tx.char_valid, 0);
         @(posedge cclk);
         #1;
         return;
      end
      for (cyc = 0; cyc < 200; cyc++) begin
         @(negedge cclk);
         if (q.size() == 0) break;
         chk("send_valid", tx.char_valid, 1);
         chk("send_busy", busy, 1);
         chk("send_char", tx.char_out, q[0]);
         chk("send_len", msg_len, q.size());
         if (mode == 1) rdy = (cyc % 4 != 1);
         else           rdy = 1'($urandom_range(0, 1));
         tx.char_ready = rdy;
         if (tap_during && cyc == 0) tap = 1'b1;
         if (cyc == 1) tap = 1'b0;
         @(posedge cclk);
         if (rdy) void'(q.pop_front());
      end
      tx.char_ready = 1'b0;
      tap = 1'b0;
      chk("send_timeout", q.size(), 0);
      chk("send_done_valid", tx.char_valid, 0);
      chk("send_done_busy", busy, 0);
      chk("send_done_len", msg_len, 0);
      @(posedge cclk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      codes = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                "..-", "...-", ".--", "-..-", "-.--", "--..",
                "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
      charset = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
      pat = "";
      tx.char_ready = 1'b0;

      repeat (3) @(posedge cclk);
      #1 rstb = 1'b1;
      @(negedge cclk);
      chk("rst_valid", tx.char_valid, 0);
      chk("rst_char", tx.char_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_len", msg_len, 0);
      chk("rst_err", err, 0);
      @(posedge cclk);
      #1;

      send_msg(0, 1'b0);

      press(3); press(10); commit();
      commit();
      press(8); commit();
      press(7); commit();
      send_msg(0, 1'b0);

      repeat (6) press(2);
      commit();
      press(2); press(9); press(2); press(9); press(2); press(9);
      commit();
      send_msg(0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         type_code(codes[$urandom_range(0, 35)]);
         commit();
      end
      send_msg(0, 1'b0);

      type_code("..."); commit();
      type_code("---"); commit();
      type_code("..."); commit();
      send_msg(1, 1'b1);
      commit();

      press(3); press(3);
      send_msg(0, 1'b0);
      commit();

      type_code(".-"); commit();
      send = 1'b1;
      @(posedge cclk);
      #1 send = 1'b0;
      tx.char_ready = 1'b1;
      @(posedge cclk);
      #1 tx.char_ready = 1'b0;
      rstb = 1'b0;
      @(posedge cclk);
      #1 rstb = 1'b1;
      q.delete();
      pat = "";
      @(negedge cclk);
      chk("midrst_valid", tx.char_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_len", msg_len, 0);
      chk("midrst_err", err, 0);
      @(posedge cclk);
      #1;

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: type_code(codes[$urandom_range(0, 35)]);
            3: begin
               int n;
               n = $urandom_range(1, 6);
               for (int k = 0; k < n; k++) press($urandom_range(1, DASH + 4));
            end
            default: ;
         endcase
         commit();
         if ($urandom_range(0, 2) == 0) send_msg($urandom_range(0, 1), 1'($urandom_range(0, 1)));
      end
      send_msg(0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
